// File: rtl/data_mem_responder.sv
// Byte-wide data-memory responder for the load/store port: one request in flight,
// writes commit and reads sample at acceptance, response after WAIT_CYCLES wait states.
module data_mem_responder #(
  parameter  int unsigned DEPTH       = 256,
  parameter  int unsigned WAIT_CYCLES = 0,
  localparam int unsigned AW          = 8,
  localparam int unsigned DW          = 8,
  localparam int unsigned TW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [DW-1:0] req_wdata_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [DW-1:0] resp_rdata_o,
  output logic          resp_err_o,
  output logic [TW-1:0] txn_count_o
);

  localparam int unsigned CW  = 4;
  localparam int unsigned AW1 = AW + 1;
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [TW-1:0] txn_q, txn_d;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          mem_we;
  logic          in_range;
  logic [IW-1:0] mem_idx;

  // Memory contents survive reset; only written at a store's accept edge.
  logic [DW-1:0] mem_q [DEPTH];

  assign in_range = (AW1'(req_addr_i) < AW1'(DEPTH));
  assign mem_idx  = req_addr_i[IW-1:0];

  // Next-state, accept decode and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    txn_d   = txn_q;
    mem_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          err_d   = ~in_range;
          rdata_d = '0;
          if (in_range) begin
            if (req_write_i) begin
              mem_we = 1'b1;
            end else begin
              rdata_d = mem_q[mem_idx];
            end
          end
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready_i) begin
          state_d = ST_IDLE;
          if (txn_q != '1) begin
            txn_d = txn_q + TW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      txn_q        <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      txn_q        <= txn_d;
      req_ready_q  <= (state_d == ST_IDLE);
      resp_valid_q <= (state_d == ST_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= req_wdata_i;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = err_q;
  assign txn_count_o  = txn_q;

  // A stalled response must hold its payload.
  a_resp_stable: assert property (@(posedge clk) disable iff (reset)
    (resp_valid_q && !resp_ready_i) |=> (resp_valid_q && $stable(rdata_q) && $stable(err_q)));

  a_one_outstanding: assert property (@(posedge clk) disable iff (reset)
    !(req_ready_q && resp_valid_q));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three parameterisations, directed vector table,
// reset/saturation sequences and randomized traffic against a memory/latency model.
module tb_data_mem_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [7:0]  req_addr   [3];
  logic [7:0]  req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [7:0]  resp_rdata [3];
  logic        resp_err   [3];
  logic [15:0] txn_count  [3];

  int n_checks;
  int n_fail;

  // Reference model: per-instance byte memory with written-flags and a transaction count.
  logic [7:0]  mdl     [3][256];
  bit          known   [3][256];
  int unsigned txn_mdl [3];

  typedef struct {
    int         d;
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         bp;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t vecs [14];

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready[0]),
    .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]), .txn_count_o(txn_count[0]));

  data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready[1]),
    .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]), .txn_count_o(txn_count[1]));

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(4)) u_dut2 (
    .clk(clk), .reset(rst[2]),
    .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_write_i(req_write[2]),
    .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .resp_valid_o(resp_valid[2]), .resp_ready_i(resp_ready[2]),
    .resp_rdata_o(resp_rdata[2]), .resp_err_o(resp_err[2]), .txn_count_o(txn_count[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(input int d);
    return (d == 1) ? 128 : 256;
  endfunction

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Drive one request, measure latency, optionally stall the response, then complete it.
  task automatic do_txn(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                        input int bp, output logic [7:0] rd, output logic er,
                        output int lat, output bit ok);
    int t;
    ok  = 1'b0;
    rd  = 8'h00;
    er  = 1'b0;
    lat = 0;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    t = 0;
    while (!req_ready[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[d]) begin
      chk("req_ready_wait", 32'(req_ready[d]), 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_addr[d]  = 8'($urandom);
    req_wdata[d] = 8'($urandom);
    @(negedge clk);
    while (!resp_valid[d] && lat < 40) begin
      chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
      resp_ready[d] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!resp_valid[d]) begin
      chk("resp_valid_wait", 32'(resp_valid[d]), 32'd1);
      resp_ready[d] = 1'b0;
      return;
    end
    rd = resp_rdata[d];
    er = resp_err[d];
    for (int i = 0; i < bp; i++) begin
      resp_ready[d] = 1'b0;
      req_valid[d]  = 1'b1;
      req_write[d]  = 1'($urandom);
      req_addr[d]   = 8'($urandom);
      req_wdata[d]  = 8'($urandom);
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid[d]), 32'd1);
      chk("bp_rdata", 32'(resp_rdata[d]), 32'(rd));
      chk("bp_err", 32'(resp_err[d]), 32'(er));
      chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("post_resp_valid", 32'(resp_valid[d]), 32'd0);
    chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    ok = 1'b1;
  endtask

  task automatic run_txn(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                         input int bp, output logic [7:0] rd, output logic er);
    bit         oor;
    bit         rd_known;
    logic [7:0] exp_rd;
    int         lat;
    bit         ok;
    oor      = (int'(a) >= depth_of(d));
    exp_rd   = (wr || oor) ? 8'h00 : mdl[d][a];
    rd_known = wr || oor || known[d][a];
    do_txn(d, wr, a, wd, bp, rd, er, lat, ok);
    if (!ok) return;
    chk("resp_err", 32'(er), 32'(oor));
    if (rd_known) chk("resp_rdata", 32'(rd), 32'(exp_rd));
    chk("latency", 32'(lat), 32'(wait_of(d)));
    if (wr && !oor) begin
      mdl[d][a]   = wd;
      known[d][a] = 1'b1;
    end
    if (txn_mdl[d] != 32'hFFFF) txn_mdl[d]++;
    chk("txn_count", 32'(txn_count[d]), txn_mdl[d]);
  endtask

  logic [7:0] g_rd;
  logic       g_er;
  int         seen;
  int         rd_idx;
  logic [7:0] r_addr;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 8'h00;
      req_wdata[d] = 8'h00; resp_ready[d] = 1'b0; txn_mdl[d] = 0;
      for (int a = 0; a < 256; a++) known[d][a] = 1'b0;
    end

    vecs[0]  = '{0, 1'b1, 8'h10, 8'h5A, 0, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h10, 8'h00, 0, 8'h5A, 1'b0};
    vecs[2]  = '{0, 1'b1, 8'hFF, 8'hA5, 1, 8'h00, 1'b0};
    vecs[3]  = '{0, 1'b0, 8'hFF, 8'h00, 2, 8'hA5, 1'b0};
    vecs[4]  = '{1, 1'b1, 8'h00, 8'h11, 0, 8'h00, 1'b0};
    vecs[5]  = '{1, 1'b1, 8'h80, 8'h77, 0, 8'h00, 1'b1};
    vecs[6]  = '{1, 1'b0, 8'h80, 8'h00, 0, 8'h00, 1'b1};
    vecs[7]  = '{1, 1'b0, 8'h00, 8'h00, 0, 8'h11, 1'b0};
    vecs[8]  = '{1, 1'b1, 8'h7F, 8'h99, 1, 8'h00, 1'b0};
    vecs[9]  = '{1, 1'b0, 8'h7F, 8'h00, 0, 8'h99, 1'b0};
    vecs[10] = '{1, 1'b0, 8'hFF, 8'h00, 0, 8'h00, 1'b1};
    vecs[11] = '{1, 1'b1, 8'h10, 8'h3C, 5, 8'h00, 1'b0};
    vecs[12] = '{1, 1'b0, 8'h10, 8'h00, 5, 8'h3C, 1'b0};
    vecs[13] = '{1, 1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", 32'(resp_rdata[d]), 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
      chk("rst_txn", 32'(txn_count[d]), 32'd0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("idle_req_ready", 32'(req_ready[d]), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      run_txn(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bp, g_rd, g_er);
      chk($sformatf("vec%0d_rdata", i), 32'(g_rd), 32'(vecs[i].exp_rdata));
      chk($sformatf("vec%0d_err", i), 32'(g_er), 32'(vecs[i].exp_err));
      if (i == 1) chk("txn0_after_2", 32'(txn_count[0]), 32'd2);
    end

    // Reset while a committed write is waiting.
    run_txn(2, 1'b1, 8'h21, 8'h44, 0, g_rd, g_er);
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 8'h20; req_wdata[2] = 8'hC3;
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    mdl[2][8'h20] = 8'hC3;
    known[2][8'h20] = 1'b1;
    repeat (2) @(negedge clk);
    rst[2] = 1'b1;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready[2]), 32'd0);
    chk("mid_rst_resp_valid", 32'(resp_valid[2]), 32'd0);
    chk("mid_rst_txn", 32'(txn_count[2]), 32'd0);
    txn_mdl[2] = 0;
    @(negedge clk);
    rst[2] = 1'b0;
    resp_ready[2] = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid[2]) seen++;
    end
    resp_ready[2] = 1'b0;
    chk("dropped_resp", 32'(seen), 32'd0);
    chk("idle_hold_ready", 32'(req_ready[2]), 32'd1);
    run_txn(2, 1'b0, 8'h20, 8'h00, 0, g_rd, g_er);
    chk("persist_rdata", 32'(g_rd), 32'hC3);
    run_txn(2, 1'b0, 8'h21, 8'h00, 0, g_rd, g_er);
    chk("persist_rdata2", 32'(g_rd), 32'h44);

    // Randomized traffic, addresses biased around the 128-byte boundary.
    for (int n = 0; n < 240; n++) begin
      rd_idx = $urandom_range(0, 2);
      r_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(8'h78 + 8'($urandom_range(0, 15)));
      run_txn(rd_idx, 1'($urandom), r_addr, 8'($urandom), $urandom_range(0, 3), g_rd, g_er);
    end

    // Counter saturation: deposit near the top instead of 65533 more transactions.
    @(negedge clk);
    u_dut0.txn_q <= 16'hFFFD;
    txn_mdl[0] = 32'hFFFD;
    @(negedge clk);
    chk("sat_preload", 32'(txn_count[0]), 32'hFFFD);
    for (int k = 0; k < 3; k++) run_txn(0, 1'b0, 8'h10, 8'h00, 0, g_rd, g_er);
    chk("sat_hold", 32'(txn_count[0]), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Byte-wide data-memory responder serving the processor's load/store port over a valid/ready request/response handshake. It accepts one request at a time, commits writes or samples read data at acceptance, and returns a response after a programmable number of wait states. It stands in for the processor's data memory so that the CPU-side memory interface can be exercised with realistic multi-cycle latency and backpressure.

## Interface

- DEPTH, 256: implemented bytes, 1..256; addresses >= DEPTH are out of range.
- WAIT_CYCLES, 0: wait states between acceptance and response, 0..15.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  reset, asynchronous, active-high; clock clk.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE and reset deasserted.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  8  byte address.
- req_wdata  input  8  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester takes response.
- resp_rdata  output  8  load data; 0 for stores and out-of-range loads.
- resp_err  output  1  address was >= DEPTH.
- txn_count  output  16  completed transactions, saturating at 16'hFFFF.

## Operation

- States: IDLE, WAIT, RESP. Reset forces IDLE.
- IDLE: req_ready=1. On req_valid at an edge, the request is accepted.
  - In-range write: mem[req_addr] <= req_wdata at the accept edge; rdata_q <= 0; err_q <= 0.
  - In-range read: rdata_q <= mem[req_addr] (pre-edge contents); err_q <= 0.
  - Out of range: no array write; rdata_q <= 0; err_q <= 1.
  - Next state is RESP if WAIT_CYCLES==0; otherwise WAIT with cnt <= WAIT_CYCLES-1.
- WAIT: req_ready=0, resp_valid=0. If cnt==0 go to RESP, else cnt <= cnt-1.
- RESP: resp_valid=1; resp_rdata=rdata_q; resp_err=err_q. Held stable until resp_ready. On resp_ready go to IDLE; txn_count increments unless already 16'hFFFF.
- Only one request is outstanding. No request is accepted in the cycle a response completes.
- req_write, req_addr and req_wdata are sampled only at the accept edge. Later changes have no effect.
- The memory array is not cleared by reset. Contents are undefined until written.

## Timing

- Reset values: req_ready=0 while reset is high, then 1. resp_valid=0, resp_rdata=0, resp_err=0, txn_count=0, cnt=0.
- If a request is accepted at edge k, resp_valid rises after edge k+WAIT_CYCLES.
- If the response handshakes at edge j, req_ready is 1 in the cycle after edge j.
- Minimum period with no backpressure: WAIT_CYCLES+2 cycles per transaction.
- Write visibility: a read accepted after a write's response sees the written data.
- Reset mid-operation (WAIT or RESP): the pending response is dropped and the state returns to IDLE. An accepted write is already committed and persists. txn_count is cleared.
- resp_ready high while resp_valid=0 has no effect. req_valid low in IDLE leaves the state in IDLE.
- At txn_count=16'hFFFF, further completions leave it unchanged.

## Test plan

- WAIT_CYCLES=0: write 0x5A to 0x10, then read 0x10 with resp_ready tied 1. Each resp_valid comes 1 cycle after its accept. The read returns resp_rdata=0x5A, resp_err=0, and txn_count ends at 2.
- WAIT_CYCLES=3: read 0x10 accepted at edge k. resp_valid rises after edge k+3. req_ready stays 0 until the cycle after the response handshake.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP while changing req_addr and req_wdata. resp_valid, resp_rdata and resp_err stay stable. The array is unchanged and no second request is accepted.
- DEPTH=128: write 0x77 to 0x80, then read 0x80. Both responses have resp_err=1 and resp_rdata=0. Reading 0x00 still returns its prior value.
- Reset during WAIT after a write of 0xC3 to 0x20 (WAIT_CYCLES=4). No response is produced and txn_count=0. A later read of 0x20 returns 0xC3.
- txn_count saturation: preload via 65535 back-to-back reads with resp_ready=1. One more completion leaves it at 16'hFFFF.
